// File: rtl/excess3_serial_decoder.sv
// Bit-serial Excess-3 to BCD decoder: collects LSB-first 4-bit codes, subtracts 3,
// and presents DIGITS decoded digits as one packed word on a valid/ready output.
module excess3_serial_decoder #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    input  logic                  in_bit,
    output logic                  in_ready,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  err,
    output logic                  busy
);

    // state   | meaning
    // COLLECT | accepting serial bits, assembling the word
    // HOLD    | complete word presented, waiting for out_ready

    localparam int DIG_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [DIG_W-1:0] LAST_DIG = DIG_W'(DIGITS - 1);

    typedef enum logic {
        COLLECT,
        HOLD
    } state_t;

    state_t                state, state_n;
    logic [1:0]            bit_cnt, bit_cnt_n;
    logic [DIG_W-1:0]      dig_cnt, dig_cnt_n;
    logic [2:0]            shift_q, shift_n;
    logic [4*DIGITS-1:0]   word_q, word_n;
    logic                  sticky_q, sticky_n;
    logic [3:0]            code;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= COLLECT;
            bit_cnt  <= '0;
            dig_cnt  <= '0;
            shift_q  <= '0;
            word_q   <= '0;
            sticky_q <= 1'b0;
        end else begin
            state    <= state_n;
            bit_cnt  <= bit_cnt_n;
            dig_cnt  <= dig_cnt_n;
            shift_q  <= shift_n;
            word_q   <= word_n;
            sticky_q <= sticky_n;
        end
    end

    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        dig_cnt_n = dig_cnt;
        shift_n   = shift_q;
        word_n    = word_q;
        sticky_n  = sticky_q;
        // bits arrive LSB-first, so the three stored bits sit right-aligned below the 4th
        code      = {in_bit, shift_q};

        if (flush) begin
            state_n   = COLLECT;
            bit_cnt_n = '0;
            dig_cnt_n = '0;
            shift_n   = '0;
            sticky_n  = 1'b0;
        end else begin
            case (state)
                COLLECT: begin
                    if (in_valid) begin
                        if (bit_cnt == 2'd3) begin
                            if (code >= 4'd3 && code <= 4'd12) begin
                                word_n[4*dig_cnt +: 4] = code - 4'd3;
                            end else begin
                                word_n[4*dig_cnt +: 4] = 4'hF;
                                sticky_n = 1'b1;
                            end
                            bit_cnt_n = '0;
                            if (dig_cnt == LAST_DIG) begin
                                dig_cnt_n = '0;
                                state_n   = HOLD;
                            end else begin
                                dig_cnt_n = dig_cnt + DIG_W'(1);
                            end
                        end else begin
                            shift_n   = {in_bit, shift_q[2:1]};
                            bit_cnt_n = bit_cnt + 2'd1;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_n  = COLLECT;
                        sticky_n = 1'b0;
                    end
                end
                default: state_n = COLLECT;
            endcase
        end
    end

    assign in_ready  = (state == COLLECT);
    assign out_valid = (state == HOLD);
    assign bcd_out   = word_q;
    assign err       = (state == HOLD) & sticky_q;
    assign busy      = (state == COLLECT) & ((bit_cnt != 2'd0) | (dig_cnt != '0));

endmodule

// File: tb/tb_excess3_serial_decoder.sv
// Self-checking bench for excess3_serial_decoder: directed scenarios plus random words
// compared against a digit-by-digit arithmetic reference model.
module tb_excess3_serial_decoder;

    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;

    logic         clk = 1'b0;
    logic         rst, flush, in_valid, in_bit, out_ready;
    logic         in_ready, out_valid, err, busy;
    logic [W-1:0] bcd_out;
    int           checks = 0;
    int           errors = 0;

    always #5 clk = ~clk;

    excess3_serial_decoder #(.DIGITS(DIGITS)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
        .in_ready  (in_ready),
        .bcd_out   (bcd_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err       (err),
        .busy      (busy)
    );

    function automatic logic [3:0] enc(input int d);
        return 4'(d + 3);
    endfunction

    task automatic ref_model(input logic [W-1:0] codes, output logic [W-1:0] word, output logic e);
        word = '0;
        e    = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            int c = int'(codes[4*k +: 4]);
            if (c >= 3 && c <= 12) begin
                word[4*k +: 4] = 4'(c - 3);
            end else begin
                word[4*k +: 4] = 4'hF;
                e = 1'b1;
            end
        end
    endtask

    task automatic push_bit(input logic b, input bit gaps);
        int n = 0;
        if (gaps) begin
            while ($urandom_range(1, 0) == 1) @(negedge clk);
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_bit   = b;
        while (in_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL push_bit_timeout in_ready=%b required 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [W-1:0] codes, input bit gaps);
        for (int k = 0; k < DIGITS; k++)
            for (int i = 0; i < 4; i++)
                push_bit(codes[4*k + i], gaps);
    endtask

    task automatic pop_word(input logic [W-1:0] exp_w, input logic exp_e, input string name, input int delay);
        int n = 0;
        while (out_valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s out_valid timeout got %b required 1", name, out_valid);
        end
        checks++;
        if (bcd_out !== exp_w) begin
            errors++;
            $display("FAIL %s bcd_out got %h required %h", name, bcd_out, exp_w);
        end
        checks++;
        if (err !== exp_e) begin
            errors++;
            $display("FAIL %s err got %b required %b", name, err, exp_e);
        end
        repeat (delay) @(negedge clk);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s out_valid_after_pop got %b required 0", name, out_valid);
        end
    endtask

    task automatic test_reset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || bcd_out !== '0 || err !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset outputs got v=%b d=%h e=%b b=%b required 0/0/0/0",
                     out_valid, bcd_out, err, busy);
        end
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset in_ready got %b required 1", in_ready);
        end
    endtask

    task automatic test_decode_1234();
        logic [W-1:0] codes = 16'h4567;
        for (int j = 0; j < W - 1; j++) push_bit(codes[j], 1'b0);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL latency_pre got v=%b busy=%b required 0/1", out_valid, busy);
        end
        push_bit(codes[W-1], 1'b0);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL latency_post out_valid got %b required 1", out_valid);
        end
        pop_word(16'h1234, 1'b0, "decode_1234", 0);
    endtask

    task automatic test_invalid();
        send_word(16'hD0C3, 1'b0);
        pop_word(16'hFF90, 1'b1, "invalid_codes", 1);
        send_word(16'hCCCC, 1'b0);
        pop_word(16'h9999, 1'b0, "sticky_cleared", 0);
    endtask

    task automatic test_backpressure();
        send_word(16'h4567, 1'b0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_bit   = 1'b1;
            checks++;
            if (in_ready !== 1'b0 || bcd_out !== 16'h1234 || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL backpressure cycle %0d got rdy=%b d=%h v=%b required 0/1234/1",
                         c, in_ready, bcd_out, out_valid);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        pop_word(16'h1234, 1'b0, "backpressure_hold", 0);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL backpressure busy got %b required 0", busy);
        end
        send_word(16'h89AB, 1'b0);
        pop_word(16'h5678, 1'b0, "after_backpressure", 0);
    endtask

    task automatic test_flush();
        logic [5:0] junk = 6'b101101;
        for (int j = 0; j < 6; j++) push_bit(junk[j], 1'b0);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL flush_pre busy got %b required 1", busy);
        end
        @(negedge clk);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_bit   = 1'b1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL flush_collect busy got %b required 0", busy);
        end
        send_word(16'h383A, 1'b0);
        pop_word(16'h0507, 1'b0, "after_flush", 0);
        // flush while a bad word is held must drop it and clear err
        send_word(16'h0000, 1'b0);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || err !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_hold got v=%b e=%b rdy=%b required 0/0/1", out_valid, err, in_ready);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] codes, exp_w;
        logic         exp_e;
        for (int w = 0; w < 200; w++) begin
            for (int k = 0; k < DIGITS; k++) begin
                if ($urandom_range(7, 0) == 0) codes[4*k +: 4] = 4'($urandom_range(15, 0));
                else                           codes[4*k +: 4] = enc(int'($urandom_range(9, 0)));
            end
            ref_model(codes, exp_w, exp_e);
            send_word(codes, 1'b1);
            pop_word(exp_w, exp_e, $sformatf("random_word_%0d", w), int'($urandom_range(3, 0)));
        end
    endtask

    task automatic test_reset_in_hold();
        send_word(16'h4567, 1'b0);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || bcd_out !== '0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_hold got v=%b d=%h e=%b required 0/0/0", out_valid, bcd_out, err);
        end
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_hold_release got rdy=%b busy=%b required 1/0", in_ready, busy);
        end
    endtask

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_bit    = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_decode_1234();
        test_invalid();
        test_backpressure();
        test_flush();
        test_random();
        test_reset_in_hold();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
